// File: rtl/ahblite_decoder_mux_if.sv
// rtl/ahblite_decoder_mux_if.sv - AHB-Lite bus bundle between master side, slave ports and decoder/mux
interface ahblite_decoder_mux_if #(
  parameter int NPORT = 4,
  parameter int CNT_W = 8
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic [NPORT-1:0]      HSEL_S;
  logic [NPORT*32-1:0]   HRDATA_S;
  logic [NPORT-1:0]      HREADYOUT_S;
  logic [NPORT-1:0]      HRESP_S;
  logic [31:0]           HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic                  DEC_ERR;
  logic [31:0]           ERR_ADDR;
  logic [CNT_W-1:0]      ERR_CNT;

  modport master (
    output HSEL, HADDR, HTRANS, HREADY, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HSEL_S, HRDATA, HREADYOUT, HRESP, DEC_ERR, ERR_ADDR, ERR_CNT
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HREADY, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HSEL_S, HRDATA, HREADYOUT, HRESP, DEC_ERR, ERR_ADDR, ERR_CNT
  );
endinterface

// File: rtl/ahblite_decoder_mux.sv
// rtl/ahblite_decoder_mux.sv - AHB-Lite base/mask address decoder, response mux and default error slave
module ahblite_decoder_mux #(
  parameter int                  NPORT     = 4,
  parameter logic [NPORT-1:0]    PORT_EN   = 4'b1111,
  parameter logic [NPORT*32-1:0] PORT_BASE = {32'h40000000, 32'h40000010, 32'h20000000, 32'h00000000},
  parameter logic [NPORT*32-1:0] PORT_MASK = {32'hFFFF0000, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFF0000},
  parameter int                  CNT_W     = 8
) (
  input  logic                HCLK,
  input  logic                HRESET,
  ahblite_decoder_mux_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NPORT-1:0]   w_match;
  logic [NPORT-1:0]   w_hsel_s;
  logic               w_nomatch;
  logic               w_err_start;
  logic               w_def_ready;
  logic               w_def_resp;
  logic [NPORT:0]     r_sel;
  logic               r_dec_err;
  logic [31:0]        r_err_addr;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [31:0]        w_hrdata;
  logic               w_hreadyout;
  logic               w_hresp;
  logic               w_unused_htrans0;

  assign w_unused_htrans0 = bus.HTRANS[0];

  // Per-port window match against base/mask; disabled ports never match
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NPORT; i++) begin
      w_match[i] = PORT_EN[i] && ((bus.HADDR & PORT_MASK[i*32 +: 32]) == PORT_BASE[i*32 +: 32]);
    end
  end

  // Lowest-index match wins: scan downwards so the last hit is the lowest index
  always_comb begin
    w_hsel_s = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hsel_s    = '0;
        w_hsel_s[i] = bus.HSEL;
      end
    end
  end

  assign w_nomatch   = bus.HSEL & ~(|w_match);
  // An error cycle pair may only start from IDLE or ERR2; ERR1 always completes first
  assign w_err_start = bus.HREADY & w_nomatch & bus.HTRANS[1] & (r_state != ST_ERR1);

  // Data-phase select register; frozen while the current data phase is stalled
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sel <= '0;
    end else if (bus.HREADY) begin
      r_sel <= {w_nomatch, w_hsel_s};
    end
  end

  // Default-slave state register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Default-slave next state and its two-cycle ERROR response
  always_comb begin
    w_state_nxt = r_state;
    w_def_ready = 1'b1;
    w_def_resp  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_err_start) w_state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        w_def_ready = 1'b0;
        w_def_resp  = 1'b1;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        w_def_ready = 1'b1;
        w_def_resp  = 1'b1;
        w_state_nxt = w_err_start ? ST_ERR1 : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Error logging: address capture, single-cycle pulse and saturating count
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dec_err  <= 1'b0;
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_dec_err <= w_err_start;
      if (w_err_start) begin
        r_err_addr <= bus.HADDR;
        if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  // Response mux: idle bus reads as zero-wait OKAY, default slave supplies ready/resp only
  always_comb begin
    w_hrdata    = '0;
    w_hreadyout = 1'b1;
    w_hresp     = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (r_sel[i]) begin
        w_hrdata    = bus.HRDATA_S[i*32 +: 32];
        w_hreadyout = bus.HREADYOUT_S[i];
        w_hresp     = bus.HRESP_S[i];
      end
    end
    if (r_sel[NPORT]) begin
      w_hrdata    = '0;
      w_hreadyout = w_def_ready;
      w_hresp     = w_def_resp;
    end
  end

  assign bus.HSEL_S    = w_hsel_s;
  assign bus.HRDATA    = w_hrdata;
  assign bus.HREADYOUT = w_hreadyout;
  assign bus.HRESP     = w_hresp;
  assign bus.DEC_ERR   = r_dec_err;
  assign bus.ERR_ADDR  = r_err_addr;
  assign bus.ERR_CNT   = r_err_cnt;

endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// tb/tb_ahblite_decoder_mux.sv - self-checking bench for the AHB-Lite decoder/mux
module tb_ahblite_decoder_mux;
  localparam int NP   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  // Address windows as inclusive [lo, hi] ranges, listed in priority order
  localparam logic [31:0] WIN_LO [NP] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0010, 32'h4000_0000};
  localparam logic [31:0] WIN_HI [NP] = '{32'h0000_FFFF, 32'h2000_FFFF, 32'h4000_001F, 32'h4000_FFFF};

  logic        HCLK   = 1'b0;
  logic        HRESET = 1'b1;
  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          m_cnt  = 0;
  logic [31:0] m_addr = '0;

  ahblite_decoder_mux_if #(.NPORT(NP), .CNT_W(CW)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahblite_decoder_mux #(.NPORT(NP), .CNT_W(CW)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  function automatic int model_port(input logic [31:0] a);
    for (int i = 0; i < NP; i++) begin
      if (a >= WIN_LO[i] && a <= WIN_HI[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_err(input logic [31:0] a);
    m_cnt  = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    m_addr = a;
  endtask

  // One transfer: address phase, then its data phase (with optional slave wait states)
  task automatic xfer(input logic [31:0] a, input logic [1:0] tr, input int waits);
    int             p;
    logic [31:0]    d [NP];
    logic [NP-1:0]  rsp;
    logic [NP-1:0]  esel;
    logic [34:0]    exp_r;
    p    = model_port(a);
    esel = '0;
    if (p >= 0) esel[p] = 1'b1;
    @(negedge HCLK);
    bus.HSEL = 1'b1; bus.HADDR = a; bus.HTRANS = tr; bus.HREADYOUT_S = '1;
    for (int i = 0; i < NP; i++) begin
      d[i] = $urandom;
      bus.HRDATA_S[i*32 +: 32] = d[i];
    end
    rsp = 4'($urandom);
    bus.HRESP_S = rsp;
    #1;
    n_cmp++;
    if (bus.HSEL_S !== esel) begin
      n_bad++; $display("FAIL hsel_s addr=%h actual=%b required=%b", a, bus.HSEL_S, esel);
    end
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.HRDATA} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL addr_phase_resp addr=%h actual=%b/%b/%b/%h required=1/0/0/0",
                        a, bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.HRDATA);
    end
    n_cmp++;
    if ({bus.ERR_ADDR, bus.ERR_CNT} !== {m_addr, CW'(m_cnt)}) begin
      n_bad++; $display("FAIL err_log addr=%h actual=%h/%0d required=%h/%0d", a, bus.ERR_ADDR, bus.ERR_CNT, m_addr, m_cnt);
    end
    if (p < 0 && tr[1]) begin
      model_err(a);
      @(negedge HCLK);
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
      #1;
      n_cmp++;
      if ({bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.HRDATA} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
        n_bad++; $display("FAIL err1 addr=%h actual=%b/%b/%b/%h required=0/1/1/0",
                          a, bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.HRDATA);
      end
      n_cmp++;
      if ({bus.ERR_ADDR, bus.ERR_CNT} !== {m_addr, CW'(m_cnt)}) begin
        n_bad++; $display("FAIL err1_log actual=%h/%0d required=%h/%0d", bus.ERR_ADDR, bus.ERR_CNT, m_addr, m_cnt);
      end
      @(negedge HCLK);
      #1;
      n_cmp++;
      if ({bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.HRDATA} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
        n_bad++; $display("FAIL err2 addr=%h actual=%b/%b/%b/%h required=1/1/0/0",
                          a, bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.HRDATA);
      end
    end else begin
      for (int w = 0; w <= waits; w++) begin
        @(negedge HCLK);
        if (p >= 0 && w < waits) begin
          bus.HREADYOUT_S[p] = 1'b0;
          bus.HSEL   = 1'b1;
          bus.HADDR  = (p == 1) ? 32'h0000_0100 : 32'h2000_0100;
          bus.HTRANS = 2'b10;
        end else begin
          bus.HREADYOUT_S = '1; bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        end
        #1;
        if (p >= 0) exp_r = {(w == waits), rsp[p], 1'b0, d[p]};
        else        exp_r = {1'b1, 1'b0, 1'b0, 32'h0};
        n_cmp++;
        if ({bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.HRDATA} !== exp_r) begin
          n_bad++; $display("FAIL data_phase addr=%h cyc=%0d actual=%b/%b/%b/%h required=%b/%b/%b/%h",
                            a, w, bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.HRDATA,
                            exp_r[34], exp_r[33], exp_r[32], exp_r[31:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge HCLK);
    #1;
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.HRDATA} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL reset_resp actual=%b/%b/%b/%h required=1/0/0/0",
                        bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.HRDATA);
    end
    n_cmp++;
    if ({bus.ERR_ADDR, bus.ERR_CNT} !== {32'h0, CW'(0)}) begin
      n_bad++; $display("FAIL reset_log actual=%h/%0d required=0/0", bus.ERR_ADDR, bus.ERR_CNT);
    end
    HRESET = 1'b0;
  endtask

  task automatic test_decode();
    xfer(32'h0000_0004, 2'b10, 0);
    xfer(32'h2000_0008, 2'b10, 0);
  endtask

  task automatic test_priority();
    xfer(32'h4000_0014, 2'b10, 0);
    xfer(32'h4000_0020, 2'b10, 0);
  endtask

  task automatic test_unmapped();
    xfer(32'h6000_0000, 2'b10, 0);
    xfer(32'h6000_0000, 2'b00, 0);
    xfer(32'h6000_0000, 2'b01, 0);
  endtask

  task automatic test_wait_states();
    xfer(32'h2000_0008, 2'b10, 3);
    xfer(32'h4000_0018, 2'b11, 2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [6];
    int          pulses;
    pulses = 0;
    for (int k = 0; k < 5; k++) a[k] = 32'h8000_0000 + 32'(k * 4);
    @(negedge HCLK);
    bus.HSEL = 1'b1; bus.HADDR = a[0]; bus.HTRANS = 2'b10; bus.HREADYOUT_S = '1;
    for (int k = 0; k < 5; k++) begin
      model_err(a[k]);
      @(negedge HCLK);
      if (k < 4) begin
        bus.HSEL = 1'b1; bus.HADDR = a[k+1]; bus.HTRANS = 2'b10;
      end else begin
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
      end
      #1;
      if (bus.DEC_ERR === 1'b1) pulses++;
      n_cmp++;
      if ({bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.ERR_ADDR} !== {1'b0, 1'b1, 1'b1, m_addr}) begin
        n_bad++; $display("FAIL b2b_err1 k=%0d actual=%b/%b/%b/%h required=0/1/1/%h",
                          k, bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.ERR_ADDR, m_addr);
      end
      @(negedge HCLK);
      #1;
      if (bus.DEC_ERR === 1'b1) pulses++;
      n_cmp++;
      if ({bus.HREADYOUT, bus.HRESP, bus.DEC_ERR} !== 3'b110) begin
        n_bad++; $display("FAIL b2b_err2 k=%0d actual=%b/%b/%b required=1/1/0",
                          k, bus.HREADYOUT, bus.HRESP, bus.DEC_ERR);
      end
    end
    n_cmp++;
    if (pulses !== 5) begin
      n_bad++; $display("FAIL b2b_pulses actual=%0d required=5", pulses);
    end
    n_cmp++;
    if (bus.ERR_CNT !== CW'(m_cnt) || m_cnt != CMAX) begin
      n_bad++; $display("FAIL b2b_saturate actual=%0d required=%0d", bus.ERR_CNT, CMAX);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = {16'h2000, 16'($urandom)};
        2:       a = {28'h4000001, 4'($urandom)};
        3:       a = {16'h4000, 16'($urandom)};
        default: a = $urandom;
      endcase
      xfer(a, 2'($urandom_range(0, 3)), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_error();
    @(negedge HCLK);
    bus.HSEL = 1'b1; bus.HADDR = 32'h7000_0000; bus.HTRANS = 2'b10; bus.HREADYOUT_S = '1;
    @(negedge HCLK);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    HRESET = 1'b1;
    #1;
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP, bus.DEC_ERR} !== 3'b011) begin
      n_bad++; $display("FAIL rst_mid_err1 actual=%b/%b/%b required=0/1/1", bus.HREADYOUT, bus.HRESP, bus.DEC_ERR);
    end
    m_cnt  = 0;
    m_addr = '0;
    @(negedge HCLK);
    #1;
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.ERR_ADDR, bus.ERR_CNT} !== {3'b100, 32'h0, CW'(0)}) begin
      n_bad++; $display("FAIL rst_mid_after actual=%b/%b/%b/%h/%0d required=1/0/0/0/0",
                        bus.HREADYOUT, bus.HRESP, bus.DEC_ERR, bus.ERR_ADDR, bus.ERR_CNT);
    end
    HRESET = 1'b0;
    xfer(32'h6000_0040, 2'b10, 0);
    xfer(32'h0000_0010, 2'b10, 1);
  endtask

  initial begin
    bus.HSEL        = 1'b0;
    bus.HADDR       = '0;
    bus.HTRANS      = 2'b00;
    bus.HRDATA_S    = '0;
    bus.HREADYOUT_S = '1;
    bus.HRESP_S     = '0;
    test_reset();
    test_decode();
    test_priority();
    test_unmapped();
    test_wait_states();
    test_back_to_back();
    test_random();
    test_reset_mid_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
